// File: rtl/uart_pkg.sv
// Shared definitions for the UART command link: FSM states, oversampling and sample points.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package uart_pkg;

    // Sample ticks per bit and the width of the counter that spans them.
    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    // Ticks inside a bit period used for majority voting (centre of the bit).
    localparam int SAMPLE_A = 7;
    localparam int SAMPLE_B = 8;
    localparam int SAMPLE_C = 9;

    localparam int DATA_W    = 8;
    localparam int BIT_CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divisor counter producing a 1-clk tick strobe every DIV enabled cycles; restart zeroes the phase.
// Latency: tick is combinational from the counter; first tick DIV cycles after restart/enable.
// Backpressure: none; the strobe is free-running while en is high.
// Ports: clk, rst (async active-low), en (count enable), restart (sync phase reset), tick (strobe out).
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !restart && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_command_rx.sv
// 8N1 UART receiver delivering command bytes on a valid/ready holding register.
// Latency: command_valid rises 1 clk after the tick-9 sample of the stop bit (~2 clk sync + 153 ticks).
// Backpressure: one-byte holding register; a byte arriving while it is full and not consumed is dropped with an overrun pulse.
// Ports: clk, rst (async active-low), rx (serial in), command/command_valid/command_ready (byte out),
//        frame_err, overrun, parity_err (1-clk pulses). Optional even parity bit: UART_RX_PARITY_EN.
module uart_command_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [uart_pkg::DATA_W-1:0] command,
    output logic                        command_valid,
    input  logic                        command_ready,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        parity_err
);
    import uart_pkg::*;

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);

    if (DIV < 1) begin : g_div_check
        $error("uart_command_rx: CLK_HZ too low for BAUD x OVERSAMPLE (DIV < 1)");
    end
    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
        $error("uart_command_rx: OVERSAMPLE must be 16");
    end

    localparam logic [TICK_W-1:0]    T_A    = TICK_W'(SAMPLE_A);
    localparam logic [TICK_W-1:0]    T_B    = TICK_W'(SAMPLE_B);
    localparam logic [TICK_W-1:0]    T_C    = TICK_W'(SAMPLE_C);
    localparam logic [TICK_W-1:0]    T_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0] B_LAST = BIT_CNT_W'(DATA_W - 1);

    logic              rx_s1, rx_s2;
    rx_state_t         state;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              s_a, s_b;
    logic              tick, start_det, at_a, at_b, at_c, at_end, maj, stop_eval, load;

    // Two-flop synchroniser; resets to the idle line level so no false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    assign start_det = (state == ST_IDLE) && !rx_s2;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (state != ST_IDLE),
        .restart (start_det),
        .tick    (tick)
    );

    assign at_a   = tick && (tick_cnt == T_A);
    assign at_b   = tick && (tick_cnt == T_B);
    assign at_c   = tick && (tick_cnt == T_C);
    assign at_end = tick && (tick_cnt == T_LAST);
    // Third vote is the live sample at tick 9, so decisions are made at that tick.
    assign maj       = maj3(s_a, s_b, rx_s2);
    assign stop_eval = (state == ST_STOP) && at_c;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    assign load = stop_eval && maj && !par_bad;
`else
    assign load = stop_eval && maj;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            s_a       <= 1'b1;
            s_b       <= 1'b1;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (start_det)  tick_cnt <= '0;
            else if (tick)  tick_cnt <= tick_cnt + 1'b1;
            if (at_a) s_a <= rx_s2;
            if (at_b) s_b <= rx_s2;

            case (state)
                ST_IDLE: begin
                    if (!rx_s2) state <= ST_START;
                end
                ST_START: begin
                    bit_cnt <= '0;
                    if (at_c && maj)  state <= ST_IDLE;   // glitch shorter than half a bit
                    else if (at_end)  state <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_c) shreg <= {maj, shreg[DATA_W-1:1]};
                    if (at_end) begin
                        if (bit_cnt == B_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity: the received bit must equal the XOR of the data.
                    if (at_c)   par_bad <= maj ^ (^shreg);
                    if (at_end) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Decide at the stop sample so the next start edge is seen early.
                    if (at_c) begin
                        state     <= maj ? ST_IDLE : ST_BREAK;
                        frame_err <= !maj;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                    end
                end
                ST_BREAK: begin
                    if (rx_s2) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a load coinciding with a handshake replaces the byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            command       <= '0;
            command_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (command_valid && !command_ready) begin
                    overrun <= 1'b1;
                end else begin
                    command       <= shreg;
                    command_valid <= 1'b1;
                end
            end else if (command_valid && command_ready) begin
                command_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_command_rx.sv
module tb_uart_command_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       command_ready = 1'b0;
    logic [7:0] command;
    logic       command_valid, frame_err, overrun, parity_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, hs_cnt = 0, last_hs_cyc = 0;
    logic [7:0] exp_q[$];

`ifdef UART_RX_PARITY_EN
    localparam int PAR_EXTRA = 16;
`else
    localparam int PAR_EXTRA = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_command_rx #(
        .CLK_HZ     (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .command       (command),
        .command_valid (command_valid),
        .command_ready (command_ready),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .parity_err    (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pulse counters and scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
            if (command_valid && command_ready) begin
                logic [31:0] e;
                hs_cnt++;
                last_hs_cyc = cyc;
                e = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
                check("byte_out", {24'h0, command}, e);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        clks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            clks(1);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, hs0, fe0, ov0, pe0;

        // Reset state
        clks(3);
        check("rst_command", {24'h0, command}, 0);
        check("rst_valid", command_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        rst = 1'b1;
        clks(5);

        // Frame 0xA5, ready high: one valid cycle, no errors, latency window
        command_ready = 1'b1;
        hs0 = hs_cnt;
        exp_q.push_back(8'hA5);
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_drain("a5_drain", 40);
        clks(5);
        check("a5_one_valid", hs_cnt - hs0, 1);
        check("a5_latency", ((last_hs_cyc - t0) >= 154 + PAR_EXTRA) && ((last_hs_cyc - t0) <= 160 + PAR_EXTRA), 1);
        check("a5_no_fe", fe_cnt, 0);
        check("a5_no_ov", ov_cnt, 0);
        check("a5_no_pe", pe_cnt, 0);

        // 0x3C then 0x7E with ready low: overrun, old byte kept
        command_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7E, 1'b1);
        clks(5);
        check("ovr_valid_held", command_valid, 1);
        check("ovr_command_kept", {24'h0, command}, 32'h3C);
        check("ovr_pulse_count", ov_cnt, 1);
        command_ready = 1'b1;
        wait_drain("ovr_drain", 10);
        clks(2);
        check("ovr_valid_cleared", command_valid, 0);

        // 0x55 with bad stop, line held low (break), then 0x12
        fe0 = fe_cnt; hs0 = hs_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        clks(40);
        rx = 1'b1;
        clks(20);
        check("fe_pulse_count", fe_cnt - fe0, 1);
        check("fe_no_valid", hs_cnt - hs0, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        wait_drain("after_break_drain", 40);

        // 5-clk glitch: nothing happens
        hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        rx = 1'b0;
        clks(5);
        rx = 1'b1;
        clks(60);
        check("glitch_no_valid", hs_cnt - hs0, 0);
        check("glitch_no_err", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);

        // Reset during data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        clks(8);
        rst = 1'b0;
        #1;
        check("midrst_command", {24'h0, command}, 0);
        check("midrst_valid", command_valid, 0);
        clks(3);
        rst = 1'b1;
        hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        clks(60);
        check("postrst_command", {24'h0, command}, 0);
        check("postrst_no_valid", hs_cnt - hs0, 0);
        check("postrst_no_err", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        wait_drain("postrst_drain", 40);

`ifdef UART_RX_PARITY_EN
        // 0x03 with wrong parity (1), then correct parity (0)
        hs0 = hs_cnt; pe0 = pe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 2);
        drive_bit(1'b1);
        drive_bit(1'b1);
        clks(10);
        check("par_pulse", pe_cnt - pe0, 1);
        check("par_no_valid", hs_cnt - hs0, 0);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1);
        wait_drain("par_ok_drain", 40);
`endif

        clks(10);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
